// File: rtl/cordic_core.sv
// cordic_core: iterative CORDIC engine, rotation mode (sin/cos/tan) and vectoring mode (atan2).
// Results carry the CORDIC gain; the downstream stage removes it.
module cordic_core #(
  parameter int ITER = 16,
  parameter int W    = 24,
  parameter int GW   = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [3:0]   select,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] angle_in,
  output logic         ready_out,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] angle,
  output logic [3:0]   select_out,
  output logic         valid_out
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic signed [W-1:0] PI = W'(32'h3243F7);
  localparam logic signed [W-1:0] HPI = W'(32'h1921FC);
  localparam logic signed [W-1:0] NHPI = -HPI;
  localparam logic signed [GW-1:0] ONE = GW'(32'h100000);
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  function automatic logic [W-1:0] atan_val(input int k);
    return k == 0 ? W'(32'h0C90FE) : k == 1 ? W'(32'h076B1A) : k == 2 ? W'(32'h03EB6F) :
           k == 3 ? W'(32'h01FD5C) : k == 4 ? W'(32'h00FFAB) : k == 5 ? W'(32'h007FF5) :
           k == 6 ? W'(32'h003FFF) : W'(32'd1 << (20 - k));
  endfunction

  // in-range when all bits above the output sign bit agree with it
  function automatic logic [W-1:0] sat(input logic signed [GW-1:0] v);
    return (&v[GW-1:W-1] || ~|v[GW-1:W-1]) ? v[W-1:0] : v[GW-1] ? SMIN : SMAX;
  endfunction

  state_t r_state, w_next;
  logic signed [GW-1:0] r_x, r_y;
  logic signed [W-1:0]  r_z;
  logic [CW-1:0]        r_i;
  logic                 r_vec, r_neg;
  logic [3:0]           r_sel;
  logic [W-1:0]         w_atan [ITER];
  logic signed [GW-1:0] w_xe, w_ye, w_x0, w_y0, w_xs, w_ys, w_xf, w_yf;
  logic signed [W-1:0]  w_ang, w_zr, w_z0;
  logic                 w_vec, w_hi, w_lo, w_d;

  for (genvar k = 0; k < ITER; k++) begin : g_atan
    assign w_atan[k] = atan_val(k);
  end

  assign ready_out = r_state == IDLE;
  assign w_vec = select == 4'b1000;
  assign w_ang = angle_in;
  assign w_hi = w_ang > HPI;
  assign w_lo = w_ang < NHPI;
  assign w_zr = w_hi ? w_ang - PI : w_lo ? w_ang + PI : w_ang;
  assign w_xe = {{(GW-W){x_in[W-1]}}, x_in};
  assign w_ye = {{(GW-W){y_in[W-1]}}, y_in};
  // vectoring with x<0: reflect into the right half-plane and preload +/-pi
  assign w_x0 = !w_vec ? ONE : x_in[W-1] ? -w_xe : w_xe;
  assign w_y0 = !w_vec ? '0 : x_in[W-1] ? -w_ye : w_ye;
  assign w_z0 = !w_vec ? w_zr : !x_in[W-1] ? '0 : y_in[W-1] ? -PI : PI;
  assign w_d = r_vec ? r_y[GW-1] : !r_z[W-1];
  assign w_xs = r_x >>> r_i;
  assign w_ys = r_y >>> r_i;
  assign w_xf = (!r_vec && r_neg) ? -r_x : r_x;
  assign w_yf = (!r_vec && r_neg) ? -r_y : r_y;

  always_comb begin
    w_next = r_state == IDLE ? (valid_in ? ROTATE : IDLE) :
             r_state == ROTATE ? (r_i == LAST ? DONE : ROTATE) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      x          <= '0;
      y          <= '0;
      angle      <= '0;
      select_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      r_state   <= w_next;
      valid_out <= r_state == DONE;
      if (r_state == IDLE && valid_in) begin
        r_x   <= w_x0;
        r_y   <= w_y0;
        r_z   <= w_z0;
        r_i   <= '0;
        r_vec <= w_vec;
        r_neg <= !w_vec && (w_hi || w_lo);
        r_sel <= select;
      end
      if (r_state == ROTATE) begin
        r_x <= w_d ? r_x - w_ys : r_x + w_ys;
        r_y <= w_d ? r_y + w_xs : r_y - w_xs;
        r_z <= w_d ? r_z - w_atan[r_i] : r_z + w_atan[r_i];
        r_i <= r_i + 1'b1;
      end
      if (r_state == DONE) begin
        x          <= sat(w_xf);
        y          <= sat(w_yf);
        angle      <= r_z;
        select_out <= r_sel;
      end
    end
  end
endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: table-driven vectors against a real-valued CORDIC model, scoreboard queue, corner sequences.
module tb_cordic_core;
  localparam int ITER = 16;

  typedef struct {
    logic [3:0]  sel;
    logic [23:0] xi, yi, ai;
    int          ex, ey, ea, ty;
  } vec_t;

  logic        clk = 0, rst = 1, valid_in = 0;
  logic [3:0]  select = '0;
  logic [23:0] x_in = '0, y_in = '0, angle_in = '0;
  logic        ready_out, valid_out;
  logic [23:0] x, y, angle;
  logic [3:0]  select_out;

  int   n_err = 0, n_chk = 0, n_valid = 0;
  real  an = 1.0;
  vec_t sbq[$];
  vec_t tab[11];

  always #5 clk = ~clk;

  cordic_core #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .select(select),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .ready_out(ready_out),
    .x(x), .y(y), .angle(angle), .select_out(select_out), .valid_out(valid_out)
  );

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    n_chk++;
    if (act - exp > tol || exp - act > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d tol %0d", nm, act, exp, tol);
    end
  endtask

  function automatic int sx(input logic [23:0] v);
    return int'({{8{v[23]}}, v});
  endfunction

  function automatic real fx2r(input logic [23:0] v);
    return $itor(sx(v)) / 1048576.0;
  endfunction

  function automatic int r2fx(input real r);
    real t = r * 1048576.0;
    t = t >= 0.0 ? t + 0.5 : t - 0.5;
    if (t > 8388607.0) return 8388607;
    if (t < -8388608.0) return -8388608;
    return $rtoi(t);
  endfunction

  function automatic vec_t mk(input logic [3:0] s, input logic [23:0] xi, input logic [23:0] yi, input logic [23:0] ai);
    vec_t v;
    real a, xr, yr;
    v.sel = s; v.xi = xi; v.yi = yi; v.ai = ai;
    if (s == 4'b1000) begin
      xr = fx2r(xi); yr = fx2r(yi);
      v.ex = r2fx(an * $sqrt(xr * xr + yr * yr));
      v.ey = 0;
      v.ea = r2fx($atan2(yr, xr));
      v.ty = 96 + v.ex / 8192;
    end else begin
      a = fx2r(ai);
      v.ex = r2fx(an * $cos(a));
      v.ey = r2fx(an * $sin(a));
      v.ea = 0;
      v.ty = 96;
    end
    return v;
  endfunction

  initial begin
    vec_t e;
    logic prev = 0;
    forever begin
      @(posedge clk); #1;
      if (valid_out && prev) chk("valid_pulse_width", 2, 1, 0);
      prev = valid_out;
      if (valid_out) begin
        n_valid++;
        if (sbq.size() == 0) chk("unexpected_valid", 1, 0, 0);
        else begin
          e = sbq.pop_front();
          chk("select_out", int'(select_out), int'(e.sel), 0);
          chk("x", sx(x), e.ex, 96);
          chk("y", sx(y), e.ey, e.ty);
          chk("angle", sx(angle), e.ea, 64);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    select = v.sel; x_in = v.xi; y_in = v.yi; angle_in = v.ai; valid_in = 1;
    sbq.push_back(v);
    @(posedge clk); #1 valid_in = 0;
  endtask

  task automatic drain(output int lat);
    lat = 0;
    while (sbq.size() != 0 && lat < 40) begin @(posedge clk); #2; lat++; end
    chk("drain_timeout", sbq.size(), 0, 0);
  endtask

  task automatic send(input vec_t v);
    int n = 0, lat;
    @(negedge clk);
    while (!ready_out && n < 40) begin @(negedge clk); n++; end
    chk("ready_wait", int'(ready_out), 1, 0);
    drive(v);
    drain(lat);
    chk("latency_from_accept_cycle", lat + 1, ITER + 2, 0);
  endtask

  initial begin
    int lat, nv;
    vec_t other;
    for (int i = 0; i < ITER; i++) an = an * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    tab[0]  = mk(4'b0001, 24'h0, 24'h0, 24'h000000);
    tab[1]  = mk(4'b0010, 24'h0, 24'h0, 24'h1921FC);
    tab[2]  = mk(4'b0001, 24'h0, 24'h0, 24'h3243F7);
    tab[3]  = mk(4'b0100, 24'h0, 24'h0, 24'hE00000);
    tab[4]  = mk(4'b0001, 24'h0, 24'h0, 24'h080000);
    tab[5]  = mk(4'b0000, 24'h0, 24'h0, 24'h100000);
    tab[6]  = mk(4'b0011, 24'h0, 24'h0, 24'hF80000);
    tab[7]  = mk(4'b1000, 24'h100000, 24'h100000, 24'h0);
    tab[8]  = mk(4'b1000, 24'hF00000, 24'h000000, 24'h0);
    tab[9]  = mk(4'b1000, 24'hF00000, 24'hFF0000, 24'h0);
    tab[10] = mk(4'b1000, 24'h7FFFFF, 24'h7FFFFF, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready_out), 1, 0);
    chk("rst_valid", int'(valid_out), 0, 0);
    chk("rst_x", sx(x), 0, 0);
    chk("rst_y", sx(y), 0, 0);
    chk("rst_angle", sx(angle), 0, 0);
    chk("rst_select", int'(select_out), 0, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 11; i++) send(tab[i]);
    chk("saturated_x", sx(x), 8388607, 0);

    @(negedge clk);
    drive(tab[4]);
    drain(lat);
    @(negedge clk);
    chk("ready_during_valid", int'({ready_out, valid_out}), 3, 0);
    drive(tab[1]);
    drain(lat);
    chk("b2b_latency", lat + 1, ITER + 2, 0);

    nv = n_valid;
    other = mk(4'b0010, 24'h0, 24'h0, 24'h080000);
    @(negedge clk);
    drive(tab[0]);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5 || c == 10) begin
        chk("busy_ready_low", int'(ready_out), 0, 0);
        select = other.sel; angle_in = other.ai; valid_in = 1;
        @(posedge clk); #1 valid_in = 0;
      end
    end
    drain(lat);
    repeat (25) @(posedge clk);
    #2;
    chk("busy_valid_count", n_valid - nv, 1, 0);

    @(negedge clk);
    drive(tab[2]);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("midrst_ready", int'(ready_out), 1, 0);
    chk("midrst_valid", int'(valid_out), 0, 0);
    chk("midrst_x", sx(x), 0, 0);
    chk("midrst_y", sx(y), 0, 0);
    chk("midrst_angle", sx(angle), 0, 0);
    chk("midrst_select", int'(select_out), 0, 0);
    sbq.delete();
    nv = n_valid;
    @(negedge clk) rst = 0;
    repeat (25) @(posedge clk);
    #2;
    chk("midrst_no_valid", n_valid - nv, 0, 0);
    send(tab[2]);
    send(tab[7]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
